ysyx_22040386_mem_stage: RTL and testbench
==========================================

Name: ysyx_22040386_mem_stage

Overview:
- Memory-access stage that consumes the execute stage's results: ALU address, store data, mem_mask, and the MemRead/MemWrite/RegWrite controls.
- Issues byte-lane-aligned requests to the data-memory port over a valid/ready request plus response-valid protocol.
- Aligns and extends load data, then hands a writeback packet to the WB stage through a valid/ready output buffer.
- Sits between the execute stage and register writeback.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX packet valid
- in_ready  out  1  stage can accept a packet
- in_alu_result  in  64  effective address
- in_mem_wr_data  in  64  store source (rs2)
- in_reg_wr_data  in  64  non-load writeback value
- in_reg_wr_addr  in  5  destination register
- in_mem_mask  in  3  funct3 size code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 treated as d
- in_RegWrite, in_MemWrite, in_MemRead  in  1 each  controls
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  64  {addr[63:3],3'b000}
- dmem_req_wen  out  1  1 = store
- dmem_req_wdata  out  64  lane-shifted store data
- dmem_req_wmask  out  8  byte enables
- dmem_resp_valid  in  1  response valid, single cycle
- dmem_resp_rdata  in  64  doubleword read data
- out_valid  out  1  writeback packet valid
- out_ready  in  1  WB accepts the packet
- out_reg_wr_addr  out  5
- out_reg_wr_data  out  64
- out_RegWrite  out  1

Behaviour:
- FSM states and transitions:
  - IDLE: accepts a packet on in_valid.
  - REQ: holds the memory request.
  - WAIT: waits for the memory response.
  - DONE: holds the writeback packet.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready): latch all inputs.
  - MemWrite|MemRead → REQ.
  - Otherwise → DONE, with out_reg_wr_data = in_reg_wr_data.
  - Latency for a non-memory packet: 1 cycle. Back-to-back non-memory packets sustain one per cycle.
- REQ:
  - dmem_req_valid=1; all request fields stay stable until dmem_req_ready.
  - On the handshake → WAIT.
  - If MemRead and MemWrite are both set, MemWrite wins and the writeback data is the latched in_reg_wr_data.
- Store lane alignment, with o = addr[2:0]:
  - wmask = size_mask << o, where size_mask is 0x01, 0x03, 0x0F or 0xFF; bits beyond 8 are dropped.
  - wdata = wr_data << 8*o.
- WAIT:
  - Valid only on a cycle after the request handshake; dmem_resp_valid is ignored in IDLE, REQ and DONE.
  - On response → DONE.
  - Load: out_reg_wr_data = extend(rdata >> 8*o), sign-extended for b/h/w, zero-extended for bu/hu/wu, unmodified for d.
  - Store: out_reg_wr_data = latched in_reg_wr_data.
- DONE:
  - out_valid=1; outputs are held while out_ready=0.
  - On out_ready: → IDLE, or accept a new packet in the same cycle.
- out_RegWrite = latched in_RegWrite. No write to x0 is suppressed here; WB handles x0.
- Reset (rst_n=0 at the clk edge), including mid-transaction:
  - state=IDLE; out_valid, dmem_req_valid, dmem_req_wen and out_RegWrite = 0.
  - All data/address/mask outputs = 0.
  - An in-flight request is abandoned; a late response arrives in IDLE and is ignored.

Optional Feature:
- Macro: YSYX_22040386_MEM_MISALIGN_CHECK_EN.
- With the macro defined:
  - Extra output out_misalign (1 bit).
  - The access is misaligned if addr is not a multiple of the access size.
  - A misaligned access skips REQ/WAIT and goes straight to DONE with out_misalign=1 and out_RegWrite=0.
  - No dmem request is issued.
  - out_misalign resets to 0 and is 0 for all aligned packets.
- Without the macro:
  - No port, no check.
  - Misaligned accesses are issued with a truncated wmask, and loads return only the in-doubleword bytes.

Decomposition:
- Shared package:
  - mem_mask encoding constants (MASK_B…MASK_WU).
  - FSM state typedef {IDLE, REQ, WAIT, DONE}.
  - size_mask lookup constants.
- One sub-module: ysyx_22040386_lsu_align, purely combinational.
  - Store wdata/wmask generation.
  - Load shift and sign/zero extension.
  - Misalign detect when the macro is set.
- The FSM and registers stay in the top module.

Test Plan:
- Non-memory stream: 3 packets with reg_wr_data 0x11, 0x22, 0x33, out_ready=1 → out_valid on 3 consecutive cycles; data 0x11, 0x22, 0x33 in order; no dmem_req_valid.
- sb: addr 0x1005, wr_data 0xAB → dmem_req_addr 0x1000, wmask 0x20, wdata 0x0000AB0000000000, wen=1.
- lb: addr 0x1003, rdata 0x00000000_80000000 → out_reg_wr_data 0xFFFFFFFFFFFFFF80. Same with lbu → 0x80.
- Backpressure: dmem_req_ready low for 3 cycles, then out_ready low for 2 cycles → request fields and out packet held stable; in_ready=0 throughout.
- Reset asserted in WAIT, then dmem_resp_valid one cycle after release → state IDLE; the response is ignored; out_valid stays 0.
- Macro on: lw at 0x1002 → no dmem request; out_misalign=1, out_RegWrite=0, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/ysyx_22040386_mem_stage_pkg.sv
// rtl/ysyx_22040386_mem_stage_pkg.sv - shared encodings for the memory-access stage
package ysyx_22040386_mem_stage_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_D  = 3'b011;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;
  localparam logic [2:0] MASK_WU = 3'b110;

  localparam logic [7:0] SIZE_MASK_B = 8'h01;
  localparam logic [7:0] SIZE_MASK_H = 8'h03;
  localparam logic [7:0] SIZE_MASK_W = 8'h0F;
  localparam logic [7:0] SIZE_MASK_D = 8'hFF;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Low two bits of the size code select the width; 111 falls into the doubleword slot.
  function automatic logic [7:0] size_mask(input logic [2:0] mem_mask);
    case (mem_mask[1:0])
      2'b00:   size_mask = SIZE_MASK_B;
      2'b01:   size_mask = SIZE_MASK_H;
      2'b10:   size_mask = SIZE_MASK_W;
      default: size_mask = SIZE_MASK_D;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040386_mem_stage_lsu_align.sv
// rtl/ysyx_22040386_mem_stage_lsu_align.sv - store lane shift, load extract/extend
// Misalign detect present only with YSYX_22040386_MEM_MISALIGN_CHECK_EN
module ysyx_22040386_lsu_align
  import ysyx_22040386_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_offset,
  input  logic [2:0]      i_mem_mask,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [7:0]      o_wmask,
  output logic [XLEN-1:0] o_load_data
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  , output logic          o_misalign
`endif
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;

  assign w_shamt   = {i_offset, 3'b000};
  assign o_wmask   = size_mask(i_mem_mask) << i_offset;
  assign o_wdata   = i_wr_data << w_shamt;
  assign w_shifted = i_rdata >> w_shamt;

  always_comb begin
    o_load_data = w_shifted;
    case (i_mem_mask)
      MASK_B:  o_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      MASK_H:  o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      MASK_W:  o_load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      MASK_BU: o_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      MASK_HU: o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      MASK_WU: o_load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_load_data = w_shifted;
    endcase
  end

`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  always_comb begin
    o_misalign = 1'b0;
    case (i_mem_mask[1:0])
      2'b00:   o_misalign = 1'b0;
      2'b01:   o_misalign = i_offset[0];
      2'b10:   o_misalign = |i_offset[1:0];
      default: o_misalign = |i_offset;
    endcase
  end
`endif

endmodule

// File: rtl/ysyx_22040386_mem_stage.sv
// rtl/ysyx_22040386_mem_stage.sv - memory-access stage: dmem request FSM and WB output buffer
// Optional misaligned-access trap: YSYX_22040386_MEM_MISALIGN_CHECK_EN
module ysyx_22040386_mem_stage
  import ysyx_22040386_mem_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_mem_wr_data,
  input  logic [XLEN-1:0]       in_reg_wr_data,
  input  logic [REG_ADDR_W-1:0] in_reg_wr_addr,
  input  logic [2:0]            in_mem_mask,
  input  logic                  in_RegWrite,
  input  logic                  in_MemWrite,
  input  logic                  in_MemRead,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_req_addr,
  output logic                  dmem_req_wen,
  output logic [XLEN-1:0]       dmem_req_wdata,
  output logic [7:0]            dmem_req_wmask,
  input  logic                  dmem_resp_valid,
  input  logic [XLEN-1:0]       dmem_resp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_reg_wr_addr,
  output logic [XLEN-1:0]       out_reg_wr_data,
  output logic                  out_RegWrite
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  , output logic                out_misalign
`endif
);

  state_t                r_state, w_next_state;
  logic [XLEN-1:0]       r_addr, r_wr_data, r_out_data;
  logic [REG_ADDR_W-1:0] r_reg_wr_addr;
  logic [2:0]            r_mask;
  logic                  r_memread, r_memwrite, r_regwrite;
  logic                  w_accept, w_mem, w_skip, w_use_latched, w_store_req;
  logic [2:0]            w_al_off, w_al_mask;
  logic [XLEN-1:0]       w_al_wr_data, w_wdata, w_load_data;
  logic [7:0]            w_wmask;
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  logic                  r_misalign, w_misalign;
`endif

  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_mem    = in_MemRead | in_MemWrite;

  // While a request is in flight the aligner works on the latched packet;
  // otherwise it looks at the incoming one so misalignment is known at accept.
  assign w_use_latched = (r_state == REQ) | (r_state == WAIT);
  assign w_al_off      = w_use_latched ? r_addr[2:0] : in_alu_result[2:0];
  assign w_al_mask     = w_use_latched ? r_mask      : in_mem_mask;
  assign w_al_wr_data  = w_use_latched ? r_wr_data   : in_mem_wr_data;

  ysyx_22040386_lsu_align #(.XLEN(XLEN)) u_align (
    .i_offset    (w_al_off),
    .i_mem_mask  (w_al_mask),
    .i_wr_data   (w_al_wr_data),
    .i_rdata     (dmem_resp_rdata),
    .o_wdata     (w_wdata),
    .o_wmask     (w_wmask),
    .o_load_data (w_load_data)
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
    , .o_misalign (w_misalign)
`endif
  );

`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  assign w_skip       = w_mem & w_misalign;
  assign out_misalign = r_misalign;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)              w_next_state = (w_mem & ~w_skip) ? REQ : DONE;
        else if (r_state == DONE && out_ready) w_next_state = IDLE;
      end
      REQ:     if (dmem_req_ready)  w_next_state = WAIT;
      WAIT:    if (dmem_resp_valid) w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_out_data    <= '0;
      r_reg_wr_addr <= '0;
      r_mask        <= '0;
      r_memread     <= 1'b0;
      r_memwrite    <= 1'b0;
      r_regwrite    <= 1'b0;
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_addr        <= in_alu_result;
      r_wr_data     <= in_mem_wr_data;
      r_out_data    <= in_reg_wr_data;
      r_reg_wr_addr <= in_reg_wr_addr;
      r_mask        <= in_mem_mask;
      r_memread     <= in_MemRead & ~w_skip;
      r_memwrite    <= in_MemWrite & ~w_skip;
      r_regwrite    <= in_RegWrite & ~w_skip;
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
      r_misalign    <= w_skip;
`endif
    end else if (r_state == WAIT && dmem_resp_valid && r_memread && !r_memwrite) begin
      r_out_data    <= w_load_data;
    end
  end

  assign w_store_req     = (r_state == REQ) & r_memwrite;
  assign dmem_req_valid  = (r_state == REQ);
  assign dmem_req_addr   = {r_addr[XLEN-1:3], 3'b000};
  assign dmem_req_wen    = r_memwrite;
  assign dmem_req_wdata  = w_store_req ? w_wdata : '0;
  assign dmem_req_wmask  = w_store_req ? w_wmask : 8'h00;

  assign out_valid       = (r_state == DONE);
  assign out_reg_wr_addr = r_reg_wr_addr;
  assign out_reg_wr_data = r_out_data;
  assign out_RegWrite    = r_regwrite;

endmodule

// File: tb/tb_ysyx_22040386_mem_stage.sv
// tb/tb_ysyx_22040386_mem_stage.sv - self-checking bench for the memory-access stage
module tb_ysyx_22040386_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_alu_result, in_mem_wr_data, in_reg_wr_data;
  logic [4:0]  in_reg_wr_addr;
  logic [2:0]  in_mem_mask;
  logic        in_RegWrite, in_MemWrite, in_MemRead;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic        out_valid, out_ready, out_RegWrite;
  logic [4:0]  out_reg_wr_addr;
  logic [63:0] out_reg_wr_data;
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040386_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_mem_wr_data(in_mem_wr_data),
    .in_reg_wr_data(in_reg_wr_data), .in_reg_wr_addr(in_reg_wr_addr),
    .in_mem_mask(in_mem_mask), .in_RegWrite(in_RegWrite),
    .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_wr_addr(out_reg_wr_addr), .out_reg_wr_data(out_reg_wr_data),
    .out_RegWrite(out_RegWrite)
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  typedef struct {
    logic [63:0] a, wd, regd, rdata;
    logic [2:0]  m;
    logic        mr, mw;
    logic [63:0] e_addr;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata, e_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-granular reference: which lanes a size/offset touches and how bytes move.
  function automatic void model(input logic [63:0] a, wd, regd, rdata, input logic [2:0] m,
                                input logic mr, mw, output logic [63:0] e_addr,
                                output logic [7:0] e_wmask, output logic [63:0] e_wdata,
                                output logic [63:0] e_out);
    int sz, o;
    logic [63:0] ld;
    sz = (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : (m[1:0] == 2'd2) ? 4 : 8;
    o = int'(a % 8);
    e_addr = a - 64'(o);
    e_wmask = 8'h00;
    e_wdata = 64'h0;
    ld = 64'h0;
    for (int i = 0; i < sz; i++)
      if (o + i < 8) e_wmask[o+i] = 1'b1;
    for (int i = 0; i + o < 8; i++) e_wdata[8*(i+o) +: 8] = wd[8*i +: 8];
    for (int i = 0; i < sz; i++)
      if (o + i < 8) ld[8*i +: 8] = rdata[8*(o+i) +: 8];
    if (!m[2] && sz < 8 && ld[8*sz-1])
      for (int b = 8 * sz; b < 64; b++) ld[b] = 1'b1;
    e_out = (mr && !mw) ? ld : regd;
  endfunction

  task automatic run_txn(input logic [63:0] a, wd, regd, rdata, input logic [2:0] m,
                         input logic mr, mw, rw, input logic [4:0] ra,
                         input int req_lat, out_lat, input logic [63:0] e_addr,
                         input logic [7:0] e_wmask, input logic [63:0] e_wdata,
                         input logic [63:0] e_out, input string tag);
    in_alu_result = a; in_mem_wr_data = wd; in_reg_wr_data = regd; in_reg_wr_addr = ra;
    in_mem_mask = m; in_MemRead = mr; in_MemWrite = mw; in_RegWrite = rw;
    in_valid = 1'b1; out_ready = 1'b0; dmem_req_ready = 1'b0;
    check({tag, ":in_ready_idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_alu_result = {$urandom, $urandom}; in_mem_wr_data = {$urandom, $urandom};
    if (mr | mw) begin
      for (int c = 0; c <= req_lat; c++) begin
        check({tag, ":req_valid"}, dmem_req_valid, 1);
        check({tag, ":req_addr"}, dmem_req_addr, e_addr);
        check({tag, ":req_wen"}, dmem_req_wen, mw);
        if (mw) begin
          check({tag, ":req_wmask"}, dmem_req_wmask, e_wmask);
          check({tag, ":req_wdata"}, dmem_req_wdata, e_wdata);
        end
        check({tag, ":in_ready_req"}, in_ready, 0);
        check({tag, ":out_valid_req"}, out_valid, 0);
        dmem_resp_valid = (c < req_lat);
        dmem_resp_rdata = {$urandom, $urandom};
        if (c == req_lat) dmem_req_ready = 1'b1;
        step();
      end
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b0;
      check({tag, ":req_valid_wait"}, dmem_req_valid, 0);
      check({tag, ":out_valid_wait"}, out_valid, 0);
      check({tag, ":in_ready_wait"}, in_ready, 0);
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rdata;
      step();
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = {$urandom, $urandom};
    end
    for (int c = 0; c <= out_lat; c++) begin
      check({tag, ":out_valid"}, out_valid, 1);
      check({tag, ":out_data"}, out_reg_wr_data, e_out);
      check({tag, ":out_addr"}, out_reg_wr_addr, ra);
      check({tag, ":out_regwrite"}, out_RegWrite, rw);
      check({tag, ":req_valid_done"}, dmem_req_valid, 0);
      check({tag, ":in_ready_done"}, in_ready, 0);
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
      check({tag, ":misalign"}, out_misalign, 0);
`endif
      if (c == out_lat) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check({tag, ":out_valid_drain"}, out_valid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":out_valid"}, out_valid, 0);
    check({tag, ":req_valid"}, dmem_req_valid, 0);
    check({tag, ":req_wen"}, dmem_req_wen, 0);
    check({tag, ":regwrite"}, out_RegWrite, 0);
    check({tag, ":req_addr"}, dmem_req_addr, 0);
    check({tag, ":req_wdata"}, dmem_req_wdata, 0);
    check({tag, ":req_wmask"}, dmem_req_wmask, 0);
    check({tag, ":out_data"}, out_reg_wr_data, 0);
    check({tag, ":out_addr"}, out_reg_wr_addr, 0);
    check({tag, ":in_ready"}, in_ready, 1);
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
    check({tag, ":misalign"}, out_misalign, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd, regd, rdata, e_addr, e_wdata, e_out, lowm;
    logic [7:0]  e_wmask;
    logic [2:0]  m;
    logic        mr, mw;
    int          kind, sz;

    rst_n = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_mem_wr_data = '0;
    in_reg_wr_data = '0; in_reg_wr_addr = '0; in_mem_mask = '0; in_RegWrite = 1'b0;
    in_MemWrite = 1'b0; in_MemRead = 1'b0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_rdata = '0; out_ready = 1'b0;
    step(); step();
    check_reset_state("reset");
    rst_n = 1'b1;

    // Non-memory stream: one packet per cycle.
    out_ready = 1'b1; in_valid = 1'b1; in_RegWrite = 1'b1; in_reg_wr_addr = 5'd3;
    check("stream:in_ready0", in_ready, 1);
    in_reg_wr_data = 64'h11;
    step();
    check("stream:v1", out_valid, 1); check("stream:d1", out_reg_wr_data, 64'h11);
    check("stream:rq1", dmem_req_valid, 0); check("stream:rdy1", in_ready, 1);
    in_reg_wr_data = 64'h22;
    step();
    check("stream:v2", out_valid, 1); check("stream:d2", out_reg_wr_data, 64'h22);
    check("stream:rq2", dmem_req_valid, 0);
    in_reg_wr_data = 64'h33;
    step();
    check("stream:v3", out_valid, 1); check("stream:d3", out_reg_wr_data, 64'h33);
    check("stream:rw3", out_RegWrite, 1); check("stream:rq3", dmem_req_valid, 0);
    in_valid = 1'b0;
    step();
    check("stream:v4", out_valid, 0);
    out_ready = 1'b0;

    vecs.push_back('{64'h1005, 64'hAB, 64'h5555, 64'h0, 3'b000, 1'b0, 1'b1,
                     64'h1000, 8'h20, 64'h0000AB0000000000, 64'h5555});
    vecs.push_back('{64'h1003, 64'h0, 64'h6666, 64'h0000000080000000, 3'b000, 1'b1, 1'b0,
                     64'h1000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80});
    vecs.push_back('{64'h1003, 64'h0, 64'h6666, 64'h0000000080000000, 3'b100, 1'b1, 1'b0,
                     64'h1000, 8'h00, 64'h0, 64'h80});
    vecs.push_back('{64'h2006, 64'h1234, 64'h7, 64'h0, 3'b001, 1'b0, 1'b1,
                     64'h2000, 8'hC0, 64'h1234000000000000, 64'h7});
    vecs.push_back('{64'h2002, 64'h0, 64'h0, 64'h0000000080010000, 3'b001, 1'b1, 1'b0,
                     64'h2000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001});
    vecs.push_back('{64'h2002, 64'h0, 64'h0, 64'h0000000080010000, 3'b101, 1'b1, 1'b0,
                     64'h2000, 8'h00, 64'h0, 64'h8001});
    vecs.push_back('{64'h3004, 64'hDEADBEEF, 64'h8, 64'h0, 3'b010, 1'b0, 1'b1,
                     64'h3000, 8'hF0, 64'hDEADBEEF00000000, 64'h8});
    vecs.push_back('{64'h3004, 64'h0, 64'h0, 64'h89ABCDEF00000000, 3'b010, 1'b1, 1'b0,
                     64'h3000, 8'h00, 64'h0, 64'hFFFFFFFF89ABCDEF});
    vecs.push_back('{64'h3004, 64'h0, 64'h0, 64'h89ABCDEF00000000, 3'b110, 1'b1, 1'b0,
                     64'h3000, 8'h00, 64'h0, 64'h0000000089ABCDEF});
    vecs.push_back('{64'h4000, 64'h0123456789ABCDEF, 64'h9, 64'h0, 3'b011, 1'b0, 1'b1,
                     64'h4000, 8'hFF, 64'h0123456789ABCDEF, 64'h9});
    vecs.push_back('{64'h4008, 64'h0, 64'h0, 64'hFEDCBA9876543210, 3'b011, 1'b1, 1'b0,
                     64'h4008, 8'h00, 64'h0, 64'hFEDCBA9876543210});
    vecs.push_back('{64'h4010, 64'h0, 64'h0, 64'hFEDCBA9876543210, 3'b111, 1'b1, 1'b0,
                     64'h4010, 8'h00, 64'h0, 64'hFEDCBA9876543210});
    vecs.push_back('{64'h1001, 64'h77, 64'h99, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b1, 1'b1,
                     64'h1000, 8'h02, 64'h0000000000007700, 64'h99});
`ifndef YSYX_22040386_MEM_MISALIGN_CHECK_EN
    vecs.push_back('{64'h1006, 64'hAABBCCDD, 64'h1, 64'h0, 3'b010, 1'b0, 1'b1,
                     64'h1000, 8'hC0, 64'hCCDD000000000000, 64'h1});
    vecs.push_back('{64'h1006, 64'h0, 64'h0, 64'h1122334455667788, 3'b010, 1'b1, 1'b0,
                     64'h1000, 8'h00, 64'h0, 64'h0000000000001122});
`endif
    foreach (vecs[i])
      run_txn(vecs[i].a, vecs[i].wd, vecs[i].regd, vecs[i].rdata, vecs[i].m, vecs[i].mr,
              vecs[i].mw, 1'(i % 2), 5'(i + 1), i % 3, (i + 1) % 3, vecs[i].e_addr,
              vecs[i].e_wmask, vecs[i].e_wdata, vecs[i].e_out, $sformatf("vec%0d", i));

    // Backpressure: request stalled 3 cycles, writeback stalled 2 cycles.
    run_txn(64'h5003, 64'hCAFE, 64'h42, 64'h0, 3'b001, 1'b0, 1'b1, 1'b1, 5'd7, 3, 2,
            64'h5000, 8'h18, 64'h000000CAFE000000, 64'h42, "bp");

    // Reset while waiting for the response; the late response must be ignored.
    in_alu_result = 64'h6000; in_mem_mask = 3'b011; in_MemRead = 1'b1; in_MemWrite = 1'b0;
    in_RegWrite = 1'b1; in_reg_wr_addr = 5'd9; in_reg_wr_data = 64'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; dmem_req_ready = 1'b1;
    check("rstwait:req_valid", dmem_req_valid, 1);
    step();
    dmem_req_ready = 1'b0;
    check("rstwait:in_wait", dmem_req_valid, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_state("rstwait");
    step();
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hDEADDEADDEADDEAD;
    step();
    dmem_resp_valid = 1'b0;
    check("rstwait:late_out_valid", out_valid, 0);
    check("rstwait:late_in_ready", in_ready, 1);
    check("rstwait:late_data", out_reg_wr_data, 0);
    step();
    check("rstwait:late_out_valid2", out_valid, 0);

`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
    in_alu_result = 64'h1002; in_mem_mask = 3'b010; in_MemRead = 1'b1; in_MemWrite = 1'b0;
    in_RegWrite = 1'b1; in_reg_wr_addr = 5'd4; in_reg_wr_data = 64'h5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mis:req_valid", dmem_req_valid, 0);
    check("mis:out_valid", out_valid, 1);
    check("mis:flag", out_misalign, 1);
    check("mis:regwrite", out_RegWrite, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mis:drain", out_valid, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = {$urandom, $urandom}; wd = {$urandom, $urandom};
      regd = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      m = 3'($urandom_range(0, 7));
      mr = (kind == 1) || (kind == 3);
      mw = (kind >= 2);
`ifdef YSYX_22040386_MEM_MISALIGN_CHECK_EN
      sz = (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : (m[1:0] == 2'd2) ? 4 : 8;
      lowm = 64'(sz - 1);
      a = a & ~lowm;
`endif
      model(a, wd, regd, rdata, m, mr, mw, e_addr, e_wmask, e_wdata, e_out);
      run_txn(a, wd, regd, rdata, m, mr, mw, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 2), $urandom_range(0, 2), e_addr, e_wmask, e_wdata, e_out,
              $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
